// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, data width and default timing/FIFO
// parameters used by both the receive and transmit sides.
package uart_pkg;

  localparam int UART_DATA_W           = 8;
  localparam int UART_CLKS_PER_BIT_DEF = 16;
  localparam int UART_FIFO_DEPTH_DEF   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous circular-buffer FIFO with registered storage, combinational head
// output, full/empty flags and an occupancy count.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH_DEF,
  parameter int WIDTH = UART_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full  = (count == LW'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: storage is cleared on reset only because the head byte must read
      // zero out of reset; larger buffers would leave the array unreset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver: input synchronizer, mid-bit sampling FSM and a byte FIFO
// presented on a valid/ready interface with receive, frame and overrun flags.
module uart_rx_capture
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = UART_FIFO_DEPTH_DEF
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          rxd,
  output logic [UART_DATA_W-1:0]        rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_int,
  output logic                          frame_err,
  output logic                          overrun_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic                   rx_meta;
  logic                   rxs;
  uart_rx_state_e         state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [2:0]             bit_idx, bit_idx_n;
  logic [UART_DATA_W-1:0] shreg, shreg_n;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   frame_err_n;
  logic                   overrun_err_n;

  assign pop      = rx_valid & rx_ready;
  assign rx_valid = ~fifo_empty;
  assign rx_int   = rx_valid;

  // Two-flop synchronizer; resets to the idle (mark) level so reset never looks like a start bit.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop capture the previous
      // stage's old value, giving two real register stages.
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      shreg       <= shreg_n;
      frame_err   <= frame_err_n;
      overrun_err <= overrun_err_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    state_n       = state;
    cnt_n         = cnt + 1'b1;
    bit_idx_n     = bit_idx;
    shreg_n       = shreg;
    push          = 1'b0;
    frame_err_n   = 1'b0;
    overrun_err_n = 1'b0;

    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (!rxs) begin
          state_n = ST_START;
        end
      end

      // Re-check the start bit at its midpoint; a high line here was only a glitch.
      ST_START: begin
        if (cnt == HALF_M1) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rxs ? ST_IDLE : ST_DATA;
        end
      end

      ST_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_n   = '0;
          shreg_n = {rxs, shreg[UART_DATA_W-1:1]};
          if (bit_idx == 3'd7) begin
            state_n = ST_STOP;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end
      end

      // Leaving at mid-stop-bit gives half a bit of slack for the next start edge.
      ST_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_n = '0;
          if (rxs) begin
            state_n = ST_IDLE;
            if (fifo_full && !pop) begin
              overrun_err_n = 1'b1;
            end else begin
              push = 1'b1;
            end
          end else begin
            frame_err_n = 1'b1;
            state_n     = ST_WAIT_IDLE;
          end
        end
      end

      ST_WAIT_IDLE: begin
        cnt_n = '0;
        if (rxs) begin
          state_n = ST_IDLE;
        end
      end

      default: begin
        cnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .push      (push),
    .push_data (shreg_n),
    .pop       (pop),
    .head      (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed bench for uart_rx_capture: serial frames are driven bit by bit, expected
// bytes go into a scoreboard queue and are compared as the consumer pops them.
module tb_uart_rx_capture;
  import uart_pkg::*;

  localparam int C  = 16;
  localparam int D  = 4;
  localparam int LW = $clog2(D) + 1;

  logic          sys_clk  = 1'b0;
  logic          sys_rst  = 1'b1;
  logic          rxd      = 1'b1;
  logic          rx_ready = 1'b0;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_int;
  logic          frame_err;
  logic          overrun_err;
  logic [LW-1:0] fifo_level;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         fe_cnt   = 0;
  int         ov_cnt   = 0;
  logic [7:0] sb[$];

  always #5 sys_clk = ~sys_clk;

  uart_rx_capture #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_int      (rx_int),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .fifo_level  (fifo_level)
  );

  // Counts high cycles of each flag; a correct one-cycle pulse adds exactly one.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (frame_err)   fe_cnt++;
      if (overrun_err) ov_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (C) @(posedge sys_clk);
    #1;
  endtask

  task automatic drive_start_data(input logic [7:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit expect_push);
    drive_start_data(d);
    drive_bit(1'b1);
    if (expect_push) sb.push_back(d);
  endtask

  task automatic pop_check(input string tag);
    int         waited = 0;
    logic [7:0] exp;
    while (!rx_valid && waited < 200) begin
      @(posedge sys_clk);
      #1;
      waited++;
    end
    check({tag, "_valid"}, 32'(rx_valid), 32'd1);
    exp = (sb.size() > 0) ? sb.pop_front() : 8'h00;
    check(tag, 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},   32'(rx_valid),    32'd0);
    check({tag, "_int"},     32'(rx_int),      32'd0);
    check({tag, "_fe"},      32'(frame_err),   32'd0);
    check({tag, "_ov"},      32'(overrun_err), 32'd0);
    check({tag, "_level"},   32'(fifo_level),  32'd0);
    check({tag, "_data"},    32'(rx_data),     32'd0);
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge sys_clk);
    #1;
    check_reset_outputs("rst");
    sys_rst = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;

    // Single byte: rx_valid rises exactly one cycle after the stop sample edge,
    // which is 11 edges into the stop bit (2 sync + half bit + 1).
    drive_start_data(8'hA5);
    rxd = 1'b1;
    repeat (10) @(posedge sys_clk);
    #1;
    check("single_pre_valid", 32'(rx_valid), 32'd0);
    @(posedge sys_clk);
    #1;
    check("single_valid", 32'(rx_valid),   32'd1);
    check("single_int",   32'(rx_int),     32'd1);
    check("single_data",  32'(rx_data),    32'hA5);
    check("single_level", 32'(fifo_level), 32'd1);
    repeat (C - 11) @(posedge sys_clk);
    #1;
    sb.push_back(8'hA5);
    pop_check("single_pop");
    check("single_empty", 32'(rx_valid), 32'd0);

    // Overrun: five back-to-back frames with the consumer stalled
    for (int k = 1; k <= 5; k++) send_frame(8'(k), k <= 4);
    check("ovr_level",  32'(fifo_level), 32'd4);
    check("ovr_pulses", 32'(ov_cnt),     32'd1);
    check("ovr_no_fe",  32'(fe_cnt),     32'd0);
    for (int k = 0; k < 4; k++) pop_check("ovr_pop");
    check("ovr_drained", 32'(fifo_level), 32'd0);

    // Framing error: stop bit held low for three bit times
    drive_start_data(8'h3C);
    for (int k = 0; k < 3; k++) drive_bit(1'b0);
    check("frm_pulses", 32'(fe_cnt),     32'd1);
    check("frm_level",  32'(fifo_level), 32'd0);
    drive_bit(1'b1);
    send_frame(8'h7E, 1'b1);
    pop_check("frm_after");
    check("frm_pulses_end", 32'(fe_cnt), 32'd1);

    // Glitch: three clocks low from idle
    rxd = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    rxd = 1'b1;
    repeat (2 * C) @(posedge sys_clk);
    #1;
    check("glitch_level", 32'(fifo_level), 32'd0);
    check("glitch_fe",    32'(fe_cnt),     32'd1);
    check("glitch_ov",    32'(ov_cnt),     32'd1);

    // Reset mid-frame: leave a byte buffered, then reset during bit 4 of 0xFF
    send_frame(8'h99, 1'b1);
    check("rstm_pre_level", 32'(fifo_level), 32'd1);
    drive_bit(1'b0);
    for (int k = 0; k < 4; k++) drive_bit(1'b1);
    rxd = 1'b1;
    repeat (C / 2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    sb.delete();
    check_reset_outputs("rstm");
    repeat (C / 2 + 4 * C) @(posedge sys_clk);
    #1;
    check("rstm_level", 32'(fifo_level), 32'd0);
    send_frame(8'h55, 1'b1);
    check("rstm_only",  32'(fifo_level), 32'd1);
    pop_check("rstm_pop");
    check("rstm_empty", 32'(fifo_level), 32'd0);
    check("rstm_fe",    32'(fe_cnt),     32'd1);
    check("rstm_ov",    32'(ov_cnt),     32'd1);

    // Full FIFO with a pop on the very edge that samples the next stop bit
    for (int k = 0; k < 4; k++) send_frame(8'(8'h10 + k), 1'b1);
    check("full_level", 32'(fifo_level), 32'd4);
    drive_start_data(8'h14);
    rxd = 1'b1;
    repeat (10) @(posedge sys_clk);
    #1;
    check("full_head", 32'(rx_data), 32'((sb.size() > 0) ? sb.pop_front() : 8'h00));
    rx_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    rx_ready = 1'b0;
    sb.push_back(8'h14);
    check("full_same_level", 32'(fifo_level), 32'd4);
    repeat (C - 11) @(posedge sys_clk);
    #1;
    check("full_no_ov",   32'(ov_cnt),     32'd1);
    check("full_level_2", 32'(fifo_level), 32'd4);
    for (int k = 0; k < 4; k++) pop_check("full_pop");
    check("full_drained", 32'(fifo_level), 32'd0);
    check("sb_empty",     32'(sb.size()),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
